// File: rtl/pipeline_pkg.sv
// Shared stage indices, stall/flush vectors and controller FSM encoding for the pipeline core.
package pipeline_pkg;

    localparam int unsigned NUM_STAGES   = 5;
    localparam int unsigned STAGE_PC     = 0;
    localparam int unsigned STAGE_IF_ID  = 1;
    localparam int unsigned STAGE_ID_EX  = 2;
    localparam int unsigned STAGE_EX_MEM = 3;
    localparam int unsigned STAGE_MEM_WB = 4;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

    // Load-use: hold PC and IF/ID, bubble ID/EX so the load can advance.
    localparam stage_vec_t STALL_LOAD_USE  = stage_vec_t'((1 << STAGE_PC) | (1 << STAGE_IF_ID));
    localparam stage_vec_t FLUSH_LOAD_USE  = stage_vec_t'(1 << STAGE_ID_EX);
    // Multi-cycle EX: freeze the front end and EX, feed bubbles into EX/MEM.
    localparam stage_vec_t STALL_MULTI     = stage_vec_t'((1 << STAGE_PC) | (1 << STAGE_IF_ID) | (1 << STAGE_ID_EX));
    localparam stage_vec_t FLUSH_MULTI     = stage_vec_t'(1 << STAGE_EX_MEM);
    localparam stage_vec_t FLUSH_EXCEPTION = stage_vec_t'((1 << STAGE_IF_ID) | (1 << STAGE_ID_EX) |
                                                          (1 << STAGE_EX_MEM) | (1 << STAGE_MEM_WB));

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/pipeline_controller_load_use_detector.sv
// Combinational load-use hazard check between the EX load destination and the ID sources.
// Zero latency; r0 never matches.
module load_use_detector #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      read_enable_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_address_1,
    input  logic                      read_enable_2,
    input  logic [REG_ADDR_WIDTH-1:0] read_address_2,
    input  logic                      write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] write_address,
    input  logic                      memory_read,
    output logic                      hazard
);

    logic load_writes;
    logic match_1;
    logic match_2;

    assign load_writes = memory_read & write_enable & (write_address != '0);
    assign match_1     = read_enable_1 & (read_address_1 == write_address);
    assign match_2     = read_enable_2 & (read_address_2 == write_address);
    assign hazard      = load_writes & (match_1 | match_2);

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: Mealy outputs from registered {state, count}; exception > multi-cycle > start > load-use.
// Multi-cycle op started at T stalls T..T+DIV_CYCLES-2 and signals done at T+DIV_CYCLES-1.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DIV_CYCLES     = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_read_enable_1,
    input  logic                      id_read_enable_2,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_address_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_address_2,
    input  logic                      ex_register_write_enable,
    input  logic [REG_ADDR_WIDTH-1:0] ex_register_write_address,
    input  logic                      ex_memory_read,
    input  logic                      ex_multicycle_start,
    input  logic                      exception_request,
    input  logic [ADDRESS_WIDTH-1:0]  exception_handler_address,
    output logic [NUM_STAGES-1:0]     stall,
    output logic [NUM_STAGES-1:0]     flush,
    output logic                      pc_redirect_enable,
    output logic [ADDRESS_WIDTH-1:0]  pc_redirect_address,
    output logic                      ex_multicycle_done,
    output logic                      ex_multicycle_cancel
);

    localparam int COUNT_WIDTH = $clog2(DIV_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(DIV_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    fsm_state_t             fsm_state;
    fsm_state_t             next_state;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] next_count;
    logic                   hazard;

    load_use_detector #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_use_detector (
        .read_enable_1  (id_read_enable_1),
        .read_address_1 (id_read_address_1),
        .read_enable_2  (id_read_enable_2),
        .read_address_2 (id_read_address_2),
        .write_enable   (ex_register_write_enable),
        .write_address  (ex_register_write_address),
        .memory_read    (ex_memory_read),
        .hazard         (hazard)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_state <= ST_RUN;
            count     <= '0;
        end else begin
            fsm_state <= next_state;
            count     <= next_count;
        end
    end

    always_comb begin
        next_state           = fsm_state;
        next_count           = count;
        stall                = '0;
        flush                = '0;
        pc_redirect_enable   = 1'b0;
        pc_redirect_address  = '0;
        ex_multicycle_done   = 1'b0;
        ex_multicycle_cancel = 1'b0;

        if (!reset) begin
            next_state = ST_RUN;
            next_count = '0;
        end else if (exception_request) begin
            flush                = FLUSH_EXCEPTION;
            pc_redirect_enable   = 1'b1;
            pc_redirect_address  = exception_handler_address;
            ex_multicycle_cancel = (fsm_state == ST_MULTI);
            next_state           = ST_RUN;
            next_count           = '0;
        end else if (fsm_state == ST_MULTI) begin
            if (count > COUNT_ONE) begin
                stall      = STALL_MULTI;
                flush      = FLUSH_MULTI;
                next_count = count - COUNT_ONE;
            end else begin
                // Op leaves EX on this edge, so the next instruction's load-use check is live now.
                ex_multicycle_done = 1'b1;
                next_state         = ST_RUN;
                next_count         = '0;
                if (hazard) begin
                    stall = STALL_LOAD_USE;
                    flush = FLUSH_LOAD_USE;
                end
            end
        end else if (ex_multicycle_start) begin
            stall      = STALL_MULTI;
            flush      = FLUSH_MULTI;
            next_state = ST_MULTI;
            next_count = COUNT_LOAD;
        end else if (hazard) begin
            stall = STALL_LOAD_USE;
            flush = FLUSH_LOAD_USE;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed vector table plus randomized traffic checked against a cycle-count reference model.
module tb_pipeline_controller;

    localparam int DIV = 4;

    typedef struct packed {
        logic        rst;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        we;
        logic [4:0]  wa;
        logic        mr;
        logic        start;
        logic        exc;
        logic [31:0] ha;
    } in_t;

    typedef struct packed {
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        redir;
        logic [31:0] raddr;
        logic        done;
        logic        cancel;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_read_enable_1, id_read_enable_2;
    logic [4:0]  id_read_address_1, id_read_address_2;
    logic        ex_register_write_enable;
    logic [4:0]  ex_register_write_address;
    logic        ex_memory_read, ex_multicycle_start, exception_request;
    logic [31:0] exception_handler_address;
    logic [4:0]  stall, flush;
    logic        pc_redirect_enable;
    logic [31:0] pc_redirect_address;
    logic        ex_multicycle_done, ex_multicycle_cancel;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an op is in flight from its start cycle until done DIV-1 cycles later.
    bit m_busy  = 1'b0;
    int m_start = 0;
    int cyc     = 0;

    vec_t  tbl[$];
    string names[$];

    pipeline_controller #(
        .REG_ADDR_WIDTH (5),
        .ADDRESS_WIDTH  (32),
        .DIV_CYCLES     (DIV)
    ) dut (
        .clock                     (clock),
        .reset                     (reset),
        .id_read_enable_1          (id_read_enable_1),
        .id_read_enable_2          (id_read_enable_2),
        .id_read_address_1         (id_read_address_1),
        .id_read_address_2         (id_read_address_2),
        .ex_register_write_enable  (ex_register_write_enable),
        .ex_register_write_address (ex_register_write_address),
        .ex_memory_read            (ex_memory_read),
        .ex_multicycle_start       (ex_multicycle_start),
        .exception_request         (exception_request),
        .exception_handler_address (exception_handler_address),
        .stall                     (stall),
        .flush                     (flush),
        .pc_redirect_enable        (pc_redirect_enable),
        .pc_redirect_address       (pc_redirect_address),
        .ex_multicycle_done        (ex_multicycle_done),
        .ex_multicycle_cancel      (ex_multicycle_cancel)
    );

    always #5 clock = ~clock;

    function automatic in_t mk(input logic rst, input logic re1, input logic [4:0] ra1,
                               input logic re2, input logic [4:0] ra2, input logic we,
                               input logic [4:0] wa, input logic mr, input logic st,
                               input logic exc, input logic [31:0] ha);
        in_t r;
        r.rst = rst; r.re1 = re1; r.ra1 = ra1; r.re2 = re2; r.ra2 = ra2;
        r.we = we; r.wa = wa; r.mr = mr; r.start = st; r.exc = exc; r.ha = ha;
        return r;
    endfunction

    function automatic out_t mko(input logic [4:0] st, input logic [4:0] fl, input logic rd,
                                 input logic [31:0] ra, input logic dn, input logic cn);
        out_t r;
        r.stall = st; r.flush = fl; r.redir = rd; r.raddr = ra; r.done = dn; r.cancel = cn;
        return r;
    endfunction

    task automatic add(input string nm, input in_t i, input out_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
        names.push_back(nm);
    endtask

    task automatic model(input in_t i, output out_t o, output bit nb, output int ns);
        bit hz;
        hz = i.mr && i.we && (i.wa != 0) &&
             ((i.re1 && i.ra1 == i.wa) || (i.re2 && i.ra2 == i.wa));
        o  = '0;
        nb = m_busy;
        ns = m_start;
        if (!i.rst) begin
            nb = 1'b0;
        end else if (i.exc) begin
            o.flush  = 5'b11110;
            o.redir  = 1'b1;
            o.raddr  = i.ha;
            o.cancel = m_busy;
            nb       = 1'b0;
        end else if (m_busy) begin
            if (cyc - m_start < DIV - 1) begin
                o.stall = 5'b00111;
                o.flush = 5'b01000;
            end else begin
                o.done = 1'b1;
                nb     = 1'b0;
                if (hz) begin
                    o.stall = 5'b00011;
                    o.flush = 5'b00100;
                end
            end
        end else if (i.start) begin
            o.stall = 5'b00111;
            o.flush = 5'b01000;
            nb      = 1'b1;
            ns      = cyc;
        end else if (hz) begin
            o.stall = 5'b00011;
            o.flush = 5'b00100;
        end
    endtask

    task automatic check(input string nm, input out_t got, input out_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got stall=%b flush=%b redir=%b addr=%h done=%b cancel=%b, expected stall=%b flush=%b redir=%b addr=%h done=%b cancel=%b",
                     nm, cyc, got.stall, got.flush, got.redir, got.raddr, got.done, got.cancel,
                     exp.stall, exp.flush, exp.redir, exp.raddr, exp.done, exp.cancel);
        end
    endtask

    task automatic step(input in_t i, input string nm, input bit has_exp, input out_t e);
        out_t m, got;
        bit   nb;
        int   ns;
        reset                     = i.rst;
        id_read_enable_1          = i.re1;
        id_read_address_1         = i.ra1;
        id_read_enable_2          = i.re2;
        id_read_address_2         = i.ra2;
        ex_register_write_enable  = i.we;
        ex_register_write_address = i.wa;
        ex_memory_read            = i.mr;
        ex_multicycle_start       = i.start;
        exception_request         = i.exc;
        exception_handler_address = i.ha;
        @(negedge clock);
        got = {stall, flush, pc_redirect_enable, pc_redirect_address,
               ex_multicycle_done, ex_multicycle_cancel};
        model(i, m, nb, ns);
        if (has_exp) check(nm, got, e);
        else         check({nm, "_model"}, got, m);
        @(posedge clock);
        m_busy  = nb;
        m_start = ns;
        cyc++;
        #1;
    endtask

    initial begin
        out_t z, multi, lu, exc_e;
        in_t  idle;
        z     = '0;
        multi = mko(5'b00111, 5'b01000, 1'b0, 32'h0, 1'b0, 1'b0);
        lu    = mko(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b0, 1'b0);
        exc_e = mko(5'b00000, 5'b11110, 1'b1, 32'h8000_0180, 1'b0, 1'b0);
        idle  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_1234);

        add("reset_0",         mk(0, 1, 5, 1, 5, 1, 5, 1, 1, 1, 32'h8000_0180), z);
        add("reset_1",         mk(0, 1, 5, 1, 5, 1, 5, 1, 1, 1, 32'h8000_0180), z);
        add("idle_after_rst",  idle, z);
        add("lu_r5",           mk(1, 1, 5, 0, 0, 1, 5, 1, 0, 0, 32'h0), lu);
        add("lu_r0",           mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0), z);
        add("lu_src2_r7",      mk(1, 0, 0, 1, 7, 1, 7, 1, 0, 0, 32'h0), lu);
        add("lu_read_off",     mk(1, 0, 5, 0, 0, 1, 5, 1, 0, 0, 32'h0), z);
        add("lu_not_load",     mk(1, 1, 5, 0, 0, 1, 5, 0, 0, 0, 32'h0), z);
        add("div_T",           mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0), multi);
        add("div_T1",          idle, multi);
        add("div_T2",          idle, multi);
        add("div_T3_done",     idle, mko(5'b0, 5'b0, 1'b0, 32'h0, 1'b1, 1'b0));
        add("div_T4",          idle, z);
        add("held_T",          mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0), multi);
        add("held_T1",         mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0), multi);
        add("held_T2",         mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0), multi);
        add("held_T3_done_lu", mk(1, 1, 3, 0, 0, 1, 3, 1, 1, 0, 32'h0),
            mko(5'b00011, 5'b00100, 1'b0, 32'h0, 1'b1, 1'b0));
        add("held_T4",         idle, z);
        add("exc_T",           mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0), multi);
        add("exc_T1_cancel",   mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0180),
            mko(5'b0, 5'b11110, 1'b1, 32'h8000_0180, 1'b0, 1'b1));
        add("exc_T2",          idle, z);
        add("exc_T3_no_done",  idle, z);
        add("exc_all_run",     mk(1, 1, 9, 0, 0, 1, 9, 1, 1, 1, 32'h8000_0180), exc_e);
        add("exc_all_next",    idle, z);
        add("rst6_T",          mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0), multi);
        add("rst6_T1",         idle, multi);
        add("rst6_T2_reset",   mk(0, 1, 4, 0, 0, 1, 4, 1, 1, 1, 32'hFFFF_FFFF), z);
        add("rst6_T3",         idle, z);
        add("rst6_T4",         idle, z);
        add("rst6_T5",         idle, z);

        @(posedge clock);
        #1;
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i, names[k], 1'b1, tbl[k].e);
        end

        for (int k = 0; k < 600; k++) begin
            in_t r;
            r.rst   = ($urandom_range(0, 39) != 0);
            r.re1   = $urandom_range(0, 1);
            r.ra1   = 5'($urandom_range(0, 3));
            r.re2   = $urandom_range(0, 1);
            r.ra2   = 5'($urandom_range(0, 3));
            r.we    = ($urandom_range(0, 3) != 0);
            r.wa    = 5'($urandom_range(0, 3));
            r.mr    = $urandom_range(0, 1);
            r.start = ($urandom_range(0, 5) == 0);
            r.exc   = ($urandom_range(0, 19) == 0);
            r.ha    = $urandom;
            step(r, "random", 1'b0, z);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
